// File: rtl/timer_dev.sv
// Purpose: programmable down-counting timer (CTRL/PRESET/COUNT) with masked interrupt to CP0.
// Latency: reads are combinational; with PRESET=P>=1, IRQ rises P+3 edges after the En=1 write.
// Backpressure: none; every write is accepted on the edge it is presented.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // ctrl bits: [0] En, [2:1] Mode, [3] IM
  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        irq_flag_q, irq_flag_d;
  state_t      state_q,    state_d;

  // Next-state: FSM first, then software writes layered on top so they win on collisions.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    state_d    = state_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Uses the registered PRESET, so a same-edge PRESET write only affects the next load.
        count_d    = preset_q;
        irq_flag_d = 1'b0;
        state_d    = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // 0 and 1 both expire here, so the count never wraps below zero.
          count_d = 32'd0;
          state_d = S_INT;
        end
      end
      S_INT: begin
        irq_flag_d = 1'b1;
        if (ctrl_q[2:1] == 2'b01) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (WE) begin
      case (Addr)
        OFS_CTRL: begin
          if (BE != 4'b0000) begin
            irq_flag_d = 1'b0;
            if (BE[0]) ctrl_d = DIn[3:0];
          end
        end
        OFS_PRESET: begin
          for (int n = 0; n < 4; n++) begin
            if (BE[n]) preset_d[8*n +: 8] = DIn[8*n +: 8];
          end
        end
        default: ;  // COUNT is read-only, offset 3 is reserved
      endcase
    end
  end

  // Register all state; reset acts immediately, independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= 4'h0;
      preset_q   <= PRESET_RST;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  // Read mux straight off the registers.
  always_comb begin
    DOut = 32'h0;
    case (Addr)
      OFS_CTRL:   DOut = {28'h0, ctrl_q};
      OFS_PRESET: DOut = preset_q;
      OFS_COUNT:  DOut = count_q;
      default:    DOut = 32'h0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_dev dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .BE   (BE),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one write on the next rising edge; returns 1 time unit after that edge.
  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    Addr = a; BE = be; DIn = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0; BE = 4'h0; DIn = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [31:0] frozen;
    logic        found;

    vecs[0]  = '{1'b0, 2'd0, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 4'hF, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 4'h4, 32'h11223344, 32'hAA22CCDD, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 4'h0, 32'hFFFFFFFF, 32'hAA22CCDD, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 4'hF, 32'h00000000, 32'hAA22CCDD, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 4'hF, 32'h00000005, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 4'hE, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 2'd0, 4'hF, 32'hFFFFFFFF, 32'h0000000F, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 4'h1, 32'h00000000, 32'h00000000, 1'b0};

    reset = 1'b0; Addr = 2'd0; WE = 1'b0; BE = 4'h0; DIn = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset after registers hold non-reset values
    wr(2'd1, 4'hF, 32'h00001234);
    wr(2'd0, 4'hF, 32'h00000009);
    repeat (4) edge1();
    do_reset();
    Addr = 2'd0; #1 chk("rst_ctrl",   DOut, 32'h0);
    Addr = 2'd1; #1 chk("rst_preset", DOut, 32'h0);
    Addr = 2'd2; #1 chk("rst_count",  DOut, 32'h0);
    Addr = 2'd3; #1 chk("rst_rsvd",   DOut, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);

    // Byte enables, read-only COUNT, reserved offset, CTRL width
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      WE = vecs[i].we; Addr = vecs[i].addr; BE = vecs[i].be; DIn = vecs[i].din;
      @(posedge clk);
      #1;
      WE = 1'b0;
      chk($sformatf("vec%0d_dout", i), DOut, vecs[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {31'h0, IRQ}, {31'h0, vecs[i].exp_irq});
    end

    // One-shot, PRESET=5: COUNT 5..0 on edges 2..7, IRQ on edge 8
    do_reset();
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    Addr = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      if (k >= 2 && k <= 7) chk($sformatf("os_count_e%0d", k), DOut, 32'(7 - k));
      chk($sformatf("os_irq_e%0d", k), {31'h0, IRQ}, (k == 8) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk("os_irq_hold", {31'h0, IRQ}, 32'h1);
    end
    Addr = 2'd0; #1 chk("os_ctrl_en_cleared", DOut, 32'h8);
    wr(2'd0, 4'hF, 32'h0);
    chk("os_irq_cleared", {31'h0, IRQ}, 32'h0);

    // PRESET=0 behaves as PRESET=1: IRQ on edge 4
    do_reset();
    wr(2'd0, 4'hF, 32'h9);
    Addr = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      edge1();
      chk($sformatf("p0_irq_e%0d", k), {31'h0, IRQ}, (k >= 4) ? 32'h1 : 32'h0);
      chk($sformatf("p0_count_e%0d", k), DOut, 32'h0);
    end

    // Auto-reload, PRESET=2: COUNT 2,1,0,0 repeating; 1-cycle IRQ every 4 edges
    do_reset();
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'hB);
    Addr = 2'd2;
    for (int k = 1; k <= 13; k++) begin
      edge1();
      if (k == 1) begin
        chk("ar_count_e1", DOut, 32'h0);
        chk("ar_irq_e1", {31'h0, IRQ}, 32'h0);
      end else begin
        case ((k - 2) % 4)
          0: v = 32'd2;
          1: v = 32'd1;
          default: v = 32'd0;
        endcase
        chk($sformatf("ar_count_e%0d", k), DOut, v);
        chk($sformatf("ar_irq_e%0d", k), {31'h0, IRQ}, ((k - 2) % 4 == 3) ? 32'h1 : 32'h0);
      end
    end

    // Pause at COUNT=6 with PRESET=10, then hold for 20 cycles
    do_reset();
    wr(2'd1, 4'hF, 32'd10);
    wr(2'd0, 4'hF, 32'h1);
    Addr = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      edge1();
      if (DOut == 32'd6) found = 1'b1;
    end
    chk("pause_reach6", {31'h0, found}, 32'h1);
    wr(2'd0, 4'h1, 32'h0);
    Addr = 2'd2;
    edge1();
    frozen = DOut;
    chk("pause_frozen_5or6", {31'h0, (frozen == 32'd5 || frozen == 32'd6)}, 32'h1);
    for (int k = 0; k < 20; k++) begin
      edge1();
      chk("pause_hold", DOut, frozen);
    end

    // Run to expiry with IM=0, then unmask via CTRL write (which clears the flag)
    wr(2'd0, 4'h1, 32'h1);
    for (int k = 0; k < 16; k++) begin
      edge1();
      chk("mask_irq_low", {31'h0, IRQ}, 32'h0);
    end
    Addr = 2'd0; #1 chk("mask_ctrl_en_cleared", DOut, 32'h0);
    Addr = 2'd2; #1 chk("mask_count_zero", DOut, 32'h0);
    wr(2'd0, 4'h1, 32'h8);
    chk("unmask_irq_low", {31'h0, IRQ}, 32'h0);
    repeat (3) edge1();
    chk("unmask_irq_still_low", {31'h0, IRQ}, 32'h0);
    Addr = 2'd0; #1 chk("unmask_ctrl", DOut, 32'h8);

    // Asynchronous reset mid-count while COUNT=3
    do_reset();
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    Addr = 2'd2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      edge1();
      if (DOut == 32'd3) found = 1'b1;
    end
    chk("async_reach3", {31'h0, found}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count_now", DOut, 32'h0);
    chk("async_irq_now", {31'h0, IRQ}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk("async_idle_count", DOut, 32'h0);
      chk("async_idle_irq", {31'h0, IRQ}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Bridge-side responder for the processor bus write port (PrWE, PrBE) and the load/store window 0x7f00–0x7f0b.
- Implements a programmable down-counting timer with three word registers: CTRL, PRESET and COUNT.
- Raises an interrupt request to the CP0 when the count expires.
- The bridge decodes the device range, then drives the word offset, write enable, byte enables and store data into this block. Load data returns combinationally.

Parameters:
- PRESET_RST, 32'h0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- Addr  input  2  word offset within the device (byte-address bits [3:2]).
- WE  input  1  write strobe; the bridge asserts it only when PrWE targets this device.
- BE  input  4  byte enables, same encoding as PrBE (bit n enables DIn[8n+7:8n]).
- DIn  input  32  store data.
- DOut  output  32  read data for the selected register (combinational).
- IRQ  output  1  interrupt request to CP0.

Behaviour:
- Register map:
  - Offset 0, CTRL. Bit [0] En, bits [2:1] Mode, bit [3] IM (interrupt mask). Bits [31:4] are not stored and read 0.
  - Offset 1, PRESET: read/write, 32 bits.
  - Offset 2, COUNT: read-only; writes are ignored.
  - Offset 3: reserved; reads 0, writes ignored.
- Reset (reset==0, asynchronous, takes effect mid-operation too):
  - CTRL=0, PRESET=PRESET_RST, COUNT=0.
  - State=IDLE, irq_flag=0.
  - Hence IRQ=0 and DOut reflects the reset register values.
- Writes:
  - Occur on the rising edge when WE=1. Only the bytes with BE[n]=1 are updated; BE=0 has no effect.
  - Any write to CTRL with BE!=0 clears irq_flag on the same edge.
- Reads: DOut=register[Addr] with zero added latency.
- Modes:
  - Mode=00 is one-shot.
  - Mode=01 is auto-reload.
  - Mode=10 and Mode=11 behave as 00.
- IRQ = irq_flag & IM.
- FSM, all transitions evaluated on the registered CTRL value:
  - IDLE: if En=1, go to LOAD; otherwise stay, and COUNT holds.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If En=0, go to IDLE with COUNT frozen.
    - Else if COUNT>1, COUNT<=COUNT-1 and stay.
    - Else (COUNT is 0 or 1), COUNT<=0 and go to INT.
  - INT:
    - irq_flag<=1.
    - Mode 00: hardware clears En; go to IDLE. irq_flag persists until a CTRL write.
    - Mode 01: go to LOAD. irq_flag is cleared when LOAD is entered, giving a 1-cycle pulse.
- Latency: with PRESET=P≥1, IRQ rises on the (P+3)th rising edge after the edge that wrote En=1. PRESET=0 behaves identically to PRESET=1.
- Simultaneous events:
  - A software CTRL write on the same edge as the INT hardware En-clear: the software value wins.
  - A PRESET write during CNT affects only the next LOAD.
  - A PRESET write on the same edge as LOAD: LOAD captures the old PRESET.
  - A COUNT write during CNT: ignored; counting continues.
- Wrap-around: COUNT never decrements below 0. PRESET=32'hFFFFFFFF counts the full range without overflow.
- DOut is combinational from registers only. No combinational path from DIn or WE to IRQ.

Test Plan:
- Reset then read:
  - Drive reset=0 with registers previously written; release.
  - Required: offsets 0, 1, 2 read 0, 0 (PRESET_RST), 0; offset 3 reads 0; IRQ=0.
- One-shot count:
  - Write PRESET=5 (BE=1111), then CTRL=32'h9 (En=1, Mode=00, IM=1).
  - Required: COUNT reads 5,4,3,2,1,0 on successive edges; IRQ=1 on the 8th edge after the CTRL write, and stays 1.
  - Required: CTRL reads 8 (En cleared). Writing CTRL=0 drops IRQ on the next edge.
- Auto-reload:
  - Write PRESET=2, CTRL=32'hB.
  - Required: IRQ is a 1-cycle pulse, repeating every 4 cycles; COUNT sequence 2,1,0,(reload)2,…
- Byte enables and read-only:
  - Write PRESET=32'hAABBCCDD (BE=1111), then DIn=32'h11223344 with BE=0100.
  - Required: PRESET reads AA22CCDD.
  - Write COUNT with 32'h5: COUNT is unchanged. Write CTRL=32'hFFFFFFFF: CTRL reads 32'hF.
- Pause and mask:
  - During CNT with PRESET=10, write CTRL with En=0 when COUNT=6.
  - Required: COUNT frozen at 5 or 6, depending on FSM lag, and verified to hold 20 cycles.
  - Run to expiry with IM=0: irq_flag set internally but IRQ=0; then set IM=1 via a CTRL write, which clears irq_flag, so IRQ stays 0.
- Async reset mid-count:
  - Assert reset between clock edges while COUNT=3 in CNT.
  - Required: COUNT=0, IRQ=0 immediately, without waiting for a clock edge; after release the FSM stays in IDLE.
